// File: rtl/div_unit_pkg.sv
// Shared widths, state encodings and handshake constants for the execute-stage divider.
package div_unit_pkg;

  localparam int unsigned RegWidth     = 32;
  localparam int unsigned DoubleRegBus = 64;
  localparam int unsigned CntWidth     = 6;
  localparam int unsigned NumIter      = 32;
  localparam int unsigned AluOpWidth   = 8;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam logic [RegWidth-1:0] ZeroWord = '0;

  // Execute decodes these to drive signed_div_i and start_i.
  localparam logic [AluOpWidth-1:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [AluOpWidth-1:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU; returns {remainder, quotient} via start/ready.
module div_unit
  import div_unit_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      signed_div_i,
  input  logic [RegWidth-1:0]       opdata1_i,
  input  logic [RegWidth-1:0]       opdata2_i,
  input  logic                      start_i,
  input  logic                      annul_i,
  output logic [DoubleRegBus-1:0]   result_o,
  output logic                      ready_o
);

  div_state_e                state_q, state_d;
  logic [CntWidth-1:0]       cnt_q, cnt_d;
  logic [2*RegWidth:0]       rq_q, rq_d;
  logic [RegWidth-1:0]       dvs_q, dvs_d;
  logic                      qneg_q, qneg_d;
  logic                      rneg_q, rneg_d;
  logic [DoubleRegBus-1:0]   result_d;
  logic                      ready_d;

  logic [2*RegWidth:0]       shifted;
  logic [RegWidth:0]         diff;
  logic [RegWidth-1:0]       abs_dividend;
  logic [RegWidth-1:0]       abs_divisor;
  logic [RegWidth-1:0]       quot_fix;
  logic [RegWidth-1:0]       rem_fix;

  // Magnitudes are taken only for signed requests with a negative operand.
  assign abs_dividend = (signed_div_i && opdata1_i[RegWidth-1])
                        ? RegWidth'(~opdata1_i + 32'd1) : opdata1_i;
  assign abs_divisor  = (signed_div_i && opdata2_i[RegWidth-1])
                        ? RegWidth'(~opdata2_i + 32'd1) : opdata2_i;

  // Borrow out of the 33-bit trial subtraction means shifted rem < divisor.
  assign shifted = rq_q << 1;
  assign diff    = (RegWidth+1)'(shifted[2*RegWidth:RegWidth] - {1'b0, dvs_q});

  assign quot_fix = qneg_q ? RegWidth'(~rq_q[RegWidth-1:0] + 32'd1) : rq_q[RegWidth-1:0];
  assign rem_fix  = rneg_q ? RegWidth'(~rq_q[2*RegWidth-1:RegWidth] + 32'd1)
                           : rq_q[2*RegWidth-1:RegWidth];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DivFree;
      cnt_q    <= '0;
      rq_q     <= '0;
      dvs_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_o <= '0;
      ready_o  <= DivResultNotReady;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rq_q     <= rq_d;
      dvs_q    <= dvs_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_o <= result_d;
      ready_o  <= ready_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rq_d     = rq_q;
    dvs_d    = dvs_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_o;
    ready_d  = ready_o;

    case (state_q)
      DivFree: begin
        if (start_i == DivStart && !annul_i) begin
          if (opdata2_i == ZeroWord) begin
            state_d = DivByZero;
          end else begin
            state_d = DivOn;
            cnt_d   = '0;
            rq_d    = {(RegWidth+1)'(0), abs_dividend};
            dvs_d   = abs_divisor;
            qneg_d  = signed_div_i & (opdata1_i[RegWidth-1] ^ opdata2_i[RegWidth-1]);
            rneg_d  = signed_div_i & opdata1_i[RegWidth-1];
          end
        end
      end

      DivByZero: begin
        state_d  = DivEnd;
        result_d = '0;
      end

      DivOn: begin
        if (annul_i) begin
          state_d  = DivFree;
          cnt_d    = '0;
          result_d = '0;
          ready_d  = DivResultNotReady;
        end else if (cnt_q != CntWidth'(NumIter)) begin
          if (!diff[RegWidth])
            rq_d = {1'b0, diff[RegWidth-1:0], shifted[RegWidth-1:1], 1'b1};
          else
            rq_d = shifted;
          cnt_d = CntWidth'(cnt_q + 6'd1);
        end else begin
          state_d  = DivEnd;
          cnt_d    = '0;
          result_d = {rem_fix, quot_fix};
          ready_d  = DivResultReady;
        end
      end

      DivEnd: begin
        if (start_i == DivStop) begin
          state_d  = DivFree;
          result_d = '0;
          ready_d  = DivResultNotReady;
        end else begin
          ready_d  = DivResultReady;
        end
      end

      default: state_d = DivFree;
    endcase
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus randomized operands vs. an arithmetic model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  // Reference: truncating division in 64-bit arithmetic, {rem, quot}; zero divisor gives 0.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint na, nb, q, r;
    if (b == 32'h0) return 64'h0;
    if (sgn) begin
      na = longint'($signed(a));
      nb = longint'($signed(b));
    end else begin
      na = longint'({32'h0, a});
      nb = longint'({32'h0, b});
    end
    q = na / nb;
    r = na % nb;
    return {r[31:0], q[31:0]};
  endfunction

  // Issues one request from FREE, returns result, edges after E0 until ready, and outputs after start drops.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        output logic [63:0] res, output int lat,
                        output logic [63:0] post_res, output logic post_rdy);
    opdata1_i    = a;
    opdata2_i    = b;
    signed_div_i = sgn;
    start_i      = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (ready_o !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res       = result_o;
    start_i   = 1'b0;
    opdata1_i = $urandom;
    opdata2_i = $urandom;
    @(posedge clk); #1;
    post_res = result_o;
    post_rdy = ready_o;
  endtask

  task automatic test_reset;
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (ready_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got %b want 0", ready_o);
    end
    n_checks++;
    if (result_o !== 64'h0) begin
      n_fail++; $display("FAIL reset_result: got %h want 0", result_o);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned;
    logic [63:0] res, pres; int lat; logic prdy;
    run_op(32'd100, 32'd7, 1'b0, res, lat, pres, prdy);
    n_checks++;
    if (res !== 64'h00000002_0000000E) begin
      n_fail++; $display("FAIL unsigned_100_7: got %h want 000000020000000e", res);
    end
    n_checks++;
    if (lat != 33) begin
      n_fail++; $display("FAIL unsigned_latency: got %0d want 33", lat);
    end
    n_checks++;
    if (prdy !== 1'b0 || pres !== 64'h0) begin
      n_fail++; $display("FAIL unsigned_drop: ready %b result %h want 0/0", prdy, pres);
    end
  endtask

  task automatic test_signed;
    logic [63:0] res, pres; int lat; logic prdy;
    run_op(32'hFFFFFFF9, 32'd2, 1'b1, res, lat, pres, prdy);
    n_checks++;
    if (res !== 64'hFFFFFFFF_FFFFFFFD) begin
      n_fail++; $display("FAIL signed_m7_2: got %h want fffffffffffffffd", res);
    end
    run_op(32'd7, 32'hFFFFFFFE, 1'b1, res, lat, pres, prdy);
    n_checks++;
    if (res !== 64'h00000001_FFFFFFFD) begin
      n_fail++; $display("FAIL signed_7_m2: got %h want 00000001fffffffd", res);
    end
    n_checks++;
    if (lat != 33) begin
      n_fail++; $display("FAIL signed_latency: got %0d want 33", lat);
    end
  endtask

  task automatic test_div_by_zero;
    logic [63:0] res, pres; int lat; logic prdy;
    for (int s = 0; s < 2; s++) begin
      run_op($urandom | 32'h1, 32'h0, 1'(s), res, lat, pres, prdy);
      n_checks++;
      if (lat != 2) begin
        n_fail++; $display("FAIL divzero_latency[%0d]: got %0d want 2", s, lat);
      end
      n_checks++;
      if (res !== 64'h0) begin
        n_fail++; $display("FAIL divzero_result[%0d]: got %h want 0", s, res);
      end
      n_checks++;
      if (prdy !== 1'b0 || pres !== 64'h0) begin
        n_fail++; $display("FAIL divzero_drop[%0d]: ready %b result %h want 0/0", s, prdy, pres);
      end
    end
  endtask

  task automatic test_overflow_operand_change;
    int lat;
    opdata1_i = 32'h80000000; opdata2_i = 32'hFFFFFFFF; signed_div_i = 1'b1; start_i = 1'b1;
    @(posedge clk); #1;
    opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = 1'b0;
    lat = 0;
    while (ready_o !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      opdata1_i = $urandom; opdata2_i = $urandom;
    end
    n_checks++;
    if (result_o !== 64'h00000000_80000000) begin
      n_fail++; $display("FAIL overflow_result: got %h want 0000000080000000", result_o);
    end
    n_checks++;
    if (lat != 33) begin
      n_fail++; $display("FAIL overflow_latency: got %0d want 33", lat);
    end
    start_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_annul;
    int lat; logic saw_ready;
    saw_ready = 1'b0;
    opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
    @(posedge clk); #1;
    repeat (10) begin
      @(posedge clk); #1;
      saw_ready |= ready_o;
    end
    annul_i = 1'b1;
    @(posedge clk); #1;
    saw_ready |= ready_o;
    n_checks++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      n_fail++; $display("FAIL annul_outputs: ready %b result %h want 0/0", ready_o, result_o);
    end
    annul_i = 1'b0;
    opdata1_i = 32'hFFFFFFFF; opdata2_i = 32'd1; signed_div_i = 1'b0;
    @(posedge clk); #1;
    lat = 0;
    while (ready_o !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (saw_ready !== 1'b0) begin
      n_fail++; $display("FAIL annul_no_ready: got %b want 0", saw_ready);
    end
    n_checks++;
    if (result_o !== 64'h00000000_FFFFFFFF || lat != 33) begin
      n_fail++; $display("FAIL annul_restart: result %h lat %0d want 00000000ffffffff/33", result_o, lat);
    end
    start_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_start_with_annul;
    int lat;
    opdata1_i = 32'd55; opdata2_i = 32'd5; signed_div_i = 1'b0;
    start_i = 1'b1; annul_i = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    annul_i = 1'b0;
    @(posedge clk); #1;
    lat = 0;
    while (ready_o !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (lat != 33 || result_o !== 64'h00000000_0000000B) begin
      n_fail++; $display("FAIL start_annul_free: lat %0d result %h want 33/000000000000000b", lat, result_o);
    end
    start_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    logic [63:0] res, pres; int lat; logic prdy;
    opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
    @(posedge clk); #1;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      n_fail++; $display("FAIL reset_mid: ready %b result %h want 0/0", ready_o, result_o);
    end
    rst = 1'b0;
    run_op(32'd100, 32'd7, 1'b0, res, lat, pres, prdy);
    n_checks++;
    if (res !== 64'h00000002_0000000E || lat != 33) begin
      n_fail++; $display("FAIL reset_mid_fresh: result %h lat %0d want 000000020000000e/33", res, lat);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] res, pres, exp; int lat; logic prdy;
    logic [31:0] a, b; logic sgn;
    for (int i = 0; i < 40; i++) begin
      a   = $urandom;
      b   = $urandom;
      sgn = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFFFFFF;
        3: a = 32'h80000000;
        4: b = b >> $urandom_range(0, 31);
        default: ;
      endcase
      exp = ref_div(a, b, sgn);
      run_op(a, b, sgn, res, lat, pres, prdy);
      n_checks++;
      if (res !== exp) begin
        n_fail++; $display("FAIL random_result[%0d] %h/%h s=%b: got %h want %h", i, a, b, sgn, res, exp);
      end
      n_checks++;
      if (lat != ((b == 32'h0) ? 2 : 33)) begin
        n_fail++; $display("FAIL random_latency[%0d]: got %0d want %0d", i, lat, (b == 32'h0) ? 2 : 33);
      end
      n_checks++;
      if (prdy !== 1'b0 || pres !== 64'h0) begin
        n_fail++; $display("FAIL random_drop[%0d]: ready %b result %h want 0/0", i, prdy, pres);
      end
    end
  endtask

  initial begin
    test_reset;
    test_unsigned;
    test_signed;
    test_div_by_zero;
    test_overflow_operand_change;
    test_annul;
    test_start_with_annul;
    test_reset_mid;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
